// File: rtl/fa_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fa_pkg : shared width limit and result struct for the fa_if adder family
// Revision: 1.0
// ---------------------------------------------------------------------------
package fa_pkg;

  localparam int WIDTH_MAX = 64;

  typedef struct packed {
    logic                 cout;
    logic [WIDTH_MAX-1:0] sum;
  } fa_result_t;

  function automatic fa_result_t fa_pack(input logic i_cout, input logic [WIDTH_MAX-1:0] i_sum);
    fa_result_t r;
    r.cout = i_cout;
    r.sum  = i_sum;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/half_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// half_adder : combinational one-bit half-adder cell
// Revision: 1.0
// ---------------------------------------------------------------------------
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule
`default_nettype wire

// File: rtl/fa_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fa_if : registered ripple-carry adder built from half-adder cells, 1-cycle latency
// Revision: 1.0
// ---------------------------------------------------------------------------
module fa_if
  import fa_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s1;
  logic [WIDTH-1:0] w_c1;
  logic [WIDTH-1:0] w_c2;
  logic [WIDTH-1:0] w_sum;

  logic             r_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  assign w_c[0] = cin;

  // Each bit: HA1 combines the operands, HA2 folds in the ripple carry.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    half_adder u_ha1 (
      .a     (a[i]),
      .b     (b[i]),
      .sum   (w_s1[i]),
      .carry (w_c1[i])
    );

    half_adder u_ha2 (
      .a     (w_s1[i]),
      .b     (w_c[i]),
      .sum   (w_sum[i]),
      .carry (w_c2[i])
    );

    assign w_c[i+1] = w_c1[i] | w_c2[i];
  end

  // Data registers load only on valid so unknown idle inputs never reach them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum  <= w_sum;
        r_cout <= w_c[WIDTH];
      end
    end
  end

  assign out_valid = r_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_fa_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fa_if : self-checking bench for fa_if at WIDTH 1, 4 and 8
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_fa_if;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       v1 = 1'b0, a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
  logic       ov1, s1, co1;
  logic       v4 = 1'b0, c4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, s4;
  logic       ov4, co4;
  logic       v8 = 1'b0, c8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic       ov8, co8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fa_if #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
    .out_valid(ov1), .sum(s1), .cout(co1)
  );
  fa_if #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .cin(c4),
    .out_valid(ov4), .sum(s4), .cout(co4)
  );
  fa_if #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .cin(c8),
    .out_valid(ov8), .sum(s8), .cout(co8)
  );

  typedef struct {
    logic a, b, cin;
    logic sum, cout;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [8:0] m8;
  logic       mv8;
  logic [1:0] t1;
  logic [4:0] t4;

  initial begin
    // Spec sequence with hand-written expectations, then the exhaustive sweep.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 8; k++) begin
      t1 = 2'(k[2]) + 2'(k[1]) + 2'(k[0]);
      tbl[4+k] = '{k[2], k[1], k[0], t1[0], t1[1]};
    end

    tick();
    tick();
    chk("reset_ov1",  64'(ov1), 64'd0);
    chk("reset_s1",   64'(s1),  64'd0);
    chk("reset_co1",  64'(co1), 64'd0);
    chk("reset_ov8",  64'(ov8), 64'd0);
    chk("reset_s8",   64'(s8),  64'd0);
    chk("reset_co8",  64'(co8), 64'd0);
    rst = 1'b0;

    // Back-to-back table vectors: out_valid must stay high every cycle.
    for (int i = 0; i < 12; i++) begin
      v1 = 1'b1; a1 = tbl[i].a; b1 = tbl[i].b; c1 = tbl[i].cin;
      if (i == 0) chk("latency_pre_ov1", 64'(ov1), 64'd0);
      tick();
      chk($sformatf("tbl%0d_sum", i),  64'(s1),  64'(tbl[i].sum));
      chk($sformatf("tbl%0d_cout", i), 64'(co1), 64'(tbl[i].cout));
      chk($sformatf("tbl%0d_ov", i),   64'(ov1), 64'd1);
    end

    // Hold: one valid (1,1,0) then three idle cycles with junk inputs, one all-X.
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      v1 = 1'b0;
      if (i == 0) begin a1 = 1'bx; b1 = 1'bx; c1 = 1'bx; end
      else begin a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom); end
      tick();
      chk($sformatf("hold%0d_sum", i),  64'(s1),  64'd0);
      chk($sformatf("hold%0d_cout", i), 64'(co1), 64'd1);
      chk($sformatf("hold%0d_ov", i),   64'(ov1), 64'd0);
    end

    // WIDTH=4 boundaries.
    v4 = 1'b1; a4 = 4'hF; b4 = 4'h0; c4 = 1'b1;
    tick();
    chk("w4_ripple_sum",  64'(s4),  64'h0);
    chk("w4_ripple_cout", 64'(co4), 64'd1);
    chk("w4_ripple_ov",   64'(ov4), 64'd1);
    a4 = 4'hA; b4 = 4'h5; c4 = 1'b0;
    tick();
    chk("w4_alt_sum",  64'(s4),  64'hF);
    chk("w4_alt_cout", 64'(co4), 64'd0);
    for (int i = 0; i < 16; i++) begin
      a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
      t4 = 5'(a4) + 5'(b4) + 5'(c4);
      tick();
      chk("w4_rand", {59'd0, co4, s4}, 64'(t4));
    end
    v4 = 1'b0;

    // Reset between edges during valid traffic on both W1 and W8.
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; c8 = 1'b1;
    tick();
    chk("pre_rst_s1",  64'(s1),  64'd1);
    chk("pre_rst_co8", 64'(co8), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ov1", 64'(ov1), 64'd0);
    chk("midrst_s1",  64'(s1),  64'd0);
    chk("midrst_co1", 64'(co1), 64'd0);
    chk("midrst_ov8", 64'(ov8), 64'd0);
    chk("midrst_s8",  64'(s8),  64'd0);
    chk("midrst_co8", 64'(co8), 64'd0);
    #1 rst = 1'b0;
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
    a8 = 8'h12; b8 = 8'h34; c8 = 1'b0;
    tick();
    chk("postrst_s1",  64'(s1),  64'd1);
    chk("postrst_co1", 64'(co1), 64'd0);
    chk("postrst_ov1", 64'(ov1), 64'd1);
    chk("postrst_s8",  64'(s8),  64'h46);
    v1 = 1'b0;

    // Random WIDTH=8 traffic against an arithmetic model with hold semantics.
    m8  = {co8, s8};
    mv8 = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      v8 = ($urandom_range(0, 3) != 0);
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      if (v8) m8 = 9'(a8) + 9'(b8) + 9'(c8);
      mv8 = v8;
      tick();
      chk("w8_rand_sum",  64'(s8),  64'(m8[7:0]));
      chk("w8_rand_cout", 64'(co8), 64'(m8[8]));
      chk("w8_rand_ov",   64'(ov8), 64'(mv8));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
